uart_rx_ctrl: RTL and testbench

Receive-side controller for the UART receiver. It generates the 16x oversampling tick and sequences the receiver enable: arm, run, and break recovery. It captures each validated byte into a 4-entry FIFO with a valid/ready output, and flags overflow, line break and inter-frame idle. It sits between the receiver and the host/bus logic, in a single clock domain.

---
 rtl/uart_rx_ctrl.sv | 166 ++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive controller: 16x tick, enable sequencing, byte FIFO, status flags
// Arms on 16 idle ticks, recovers from line breaks, and reports overflow, break and idle.
module uart_rx_ctrl #(
    parameter int FIFO_DEPTH  = 4,
    parameter int DIV_W       = 16,
    parameter int IDLE_CHARS  = 2,
    parameter int BREAK_TICKS = 176
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [DIV_W-1:0]              baud_div,
    input  logic                          i_rx,
    output logic                          rx_en,
    output logic                          baud_tick,
    input  logic [7:0]                    rx_o_data,
    input  logic                          rx_o_data_valid,
    output logic [7:0]                    m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          break_det,
    output logic                          idle_irq,
    input  logic                          clr_status
);

    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int CW       = AW + 1;
    localparam int LW       = $clog2(BREAK_TICKS + 1);
    localparam int IDLE_LIM = IDLE_CHARS * 176;
    localparam int IW       = $clog2(IDLE_LIM + 1);

    typedef enum logic [1:0] {OFF, ARM, RUN, RECOVER} state_t;

    state_t           state, state_nxt;
    logic [1:0]       sync;
    logic             rxs;
    logic [DIV_W-1:0] div_cnt;
    logic [4:0]       high_cnt;
    logic [LW-1:0]    low_cnt;
    logic [IW-1:0]    idle_cnt;
    logic             armed;
    logic             prev_valid;
    logic             brk_set;
    logic             push, pop, full, wr_en, ovf_set, idle_fire;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;

    assign rxs        = sync[1];
    assign rx_en      = (state == RUN);
    assign m_valid    = (count != '0);
    assign m_data     = mem[rd_ptr];
    assign fifo_count = count;
    assign full       = (count == CW'(FIFO_DEPTH));
    assign pop        = m_valid && m_ready;
    assign push       = (state == RUN) && rx_o_data_valid && !prev_valid;
    assign wr_en      = push && (!full || pop);
    assign ovf_set    = push && full && !pop;
    assign idle_fire  = (state == RUN) && !push && baud_tick && rxs && armed
                        && (idle_cnt == IW'(IDLE_LIM - 1));

    // Live compare against baud_div: lowering it below the count runs the counter to wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync      <= 2'b11;
            div_cnt   <= '0;
            baud_tick <= 1'b0;
        end else begin
            sync <= {sync[0], i_rx};
            if (!enable) begin
                div_cnt   <= '0;
                baud_tick <= 1'b0;
            end else if (div_cnt == baud_div) begin
                div_cnt   <= '0;
                baud_tick <= 1'b1;
            end else begin
                div_cnt   <= div_cnt + DIV_W'(1);
                baud_tick <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        brk_set   = 1'b0;
        if (!enable) begin
            state_nxt = OFF;
        end else begin
            case (state)
                OFF:     state_nxt = ARM;
                ARM:     if (baud_tick && rxs && high_cnt == 5'd15) state_nxt = RUN;
                RUN: begin
                    if (baud_tick && !rxs && low_cnt == LW'(BREAK_TICKS - 1)) begin
                        state_nxt = RECOVER;
                        brk_set   = 1'b1;
                    end
                end
                RECOVER: if (rxs) state_nxt = ARM;
                default: state_nxt = OFF;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= OFF;
            high_cnt   <= '0;
            low_cnt    <= '0;
            idle_cnt   <= '0;
            armed      <= 1'b0;
            idle_irq   <= 1'b0;
            prev_valid <= 1'b0;
            overflow   <= 1'b0;
            break_det  <= 1'b0;
        end else begin
            state      <= state_nxt;
            prev_valid <= rx_o_data_valid;
            idle_irq   <= idle_fire;

            if (state != ARM)   high_cnt <= '0;
            else if (baud_tick) high_cnt <= rxs ? high_cnt + 5'd1 : 5'd0;

            if (state != RUN)   low_cnt <= '0;
            else if (baud_tick) low_cnt <= rxs ? '0 : low_cnt + LW'(1);

            // Saturate so a long idle line never wraps back into a second pulse.
            if (state != RUN || push) idle_cnt <= '0;
            else if (baud_tick) begin
                if (!rxs)                          idle_cnt <= '0;
                else if (idle_cnt != IW'(IDLE_LIM)) idle_cnt <= idle_cnt + IW'(1);
            end

            if (push)           armed <= 1'b1;
            else if (idle_fire) armed <= 1'b0;

            if (ovf_set)         overflow <= 1'b1;
            else if (clr_status) overflow <= 1'b0;

            if (brk_set)         break_det <= 1'b1;
            else if (clr_status) break_det <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= rx_o_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [15:0] baud_div;
    logic        i_rx;
    logic        rx_en;
    logic        baud_tick;
    logic [7:0]  rx_o_data;
    logic        rx_o_data_valid;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic [2:0]  fifo_count;
    logic        overflow;
    logic        break_det;
    logic        idle_irq;
    logic        clr_status;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    uart_rx_ctrl dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .baud_div(baud_div), .i_rx(i_rx),
        .rx_en(rx_en), .baud_tick(baud_tick), .rx_o_data(rx_o_data),
        .rx_o_data_valid(rx_o_data_valid), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .fifo_count(fifo_count), .overflow(overflow),
        .break_det(break_det), .idle_irq(idle_irq), .clr_status(clr_status)
    );

    typedef struct {
        logic [7:0] d;
        logic       v, r, c;
        logic       ev;
        logic [7:0] ed;
        logic       cd;
        logic [2:0] en;
        logic       eo;
    } vec_t;

    vec_t tbl [22];

    function automatic vec_t mk(int d, int v, int r, int c, int ev, int ed, int cd, int en, int eo);
        vec_t x;
        x.d  = 8'(d);  x.v  = 1'(v);  x.r = 1'(r);  x.c = 1'(c);
        x.ev = 1'(ev); x.ed = 8'(ed); x.cd = 1'(cd); x.en = 3'(en); x.eo = 1'(eo);
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d);
        rx_o_data       = d;
        rx_o_data_valid = 1'b1;
        step();
        rx_o_data_valid = 1'b0;
    endtask

    initial begin
        int pulses;
        int at;
        int bad;

        tbl[0]  = mk(8'hA5, 1, 0, 0, 1, 8'hA5, 1, 1, 0);
        tbl[1]  = mk(8'hA5, 1, 0, 0, 1, 8'hA5, 1, 1, 0);
        tbl[2]  = mk(8'hA5, 1, 0, 0, 1, 8'hA5, 1, 1, 0);
        tbl[3]  = mk(8'hA5, 0, 1, 0, 0, 0,     0, 0, 0);
        tbl[4]  = mk(8'h11, 1, 0, 0, 1, 8'h11, 1, 1, 0);
        tbl[5]  = mk(8'h11, 0, 0, 0, 1, 8'h11, 1, 1, 0);
        tbl[6]  = mk(8'h22, 1, 0, 0, 1, 8'h11, 1, 2, 0);
        tbl[7]  = mk(8'h22, 0, 0, 0, 1, 8'h11, 1, 2, 0);
        tbl[8]  = mk(8'h33, 1, 0, 0, 1, 8'h11, 1, 3, 0);
        tbl[9]  = mk(8'h33, 0, 0, 0, 1, 8'h11, 1, 3, 0);
        tbl[10] = mk(8'h44, 1, 0, 0, 1, 8'h11, 1, 4, 0);
        tbl[11] = mk(8'h44, 0, 0, 0, 1, 8'h11, 1, 4, 0);
        tbl[12] = mk(8'h55, 1, 0, 0, 1, 8'h11, 1, 4, 1);
        tbl[13] = mk(8'h55, 0, 0, 0, 1, 8'h11, 1, 4, 1);
        tbl[14] = mk(8'h66, 1, 1, 0, 1, 8'h22, 1, 4, 1);
        tbl[15] = mk(8'h66, 0, 0, 1, 1, 8'h22, 1, 4, 0);
        tbl[16] = mk(8'h66, 0, 1, 0, 1, 8'h33, 1, 3, 0);
        tbl[17] = mk(8'h00, 0, 1, 0, 1, 8'h44, 1, 2, 0);
        tbl[18] = mk(8'h00, 0, 1, 0, 1, 8'h66, 1, 1, 0);
        tbl[19] = mk(8'h00, 0, 1, 0, 0, 0,     0, 0, 0);
        tbl[20] = mk(8'h77, 1, 1, 0, 1, 8'h77, 1, 1, 0);
        tbl[21] = mk(8'h77, 0, 1, 0, 0, 0,     0, 0, 0);

        rst_n = 1'b0; enable = 1'b0; baud_div = 16'd3; i_rx = 1'b0;
        rx_o_data = 8'h00; rx_o_data_valid = 1'b0; m_ready = 1'b0; clr_status = 1'b0;
        repeat (3) step();
        check("rst_rx_en", 32'(rx_en), 0);
        check("rst_tick", 32'(baud_tick), 0);
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_count", 32'(fifo_count), 0);
        check("rst_m_data", 32'(m_data), 0);
        check("rst_flags", 32'({overflow, break_det, idle_irq}), 0);
        rst_n = 1'b1;
        repeat (2) step();

        // Divider: baud_div=3 -> tick on every 4th clk after enable
        enable = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            check($sformatf("div3_tick_%0d", k), 32'(baud_tick), 32'((k % 4) == 0));
        end
        enable = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("div_off_%0d", k), 32'(baud_tick), 0);
        end
        baud_div = 16'd0;
        enable   = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("div0_tick_%0d", k), 32'(baud_tick), 1);
        end

        // Arm: line held low keeps the receiver off
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (rx_en) bad = 1;
        end
        check("arm_line_low", 32'(bad), 0);
        i_rx = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            step();
            if (k == 17) check("arm_before_16", 32'(rx_en), 0);
            if (k == 18) check("arm_at_16", 32'(rx_en), 1);
        end

        // Capture and FIFO vectors
        for (int i = 0; i < 22; i++) begin
            rx_o_data       = tbl[i].d;
            rx_o_data_valid = tbl[i].v;
            m_ready         = tbl[i].r;
            clr_status      = tbl[i].c;
            step();
            check($sformatf("vec%0d_m_valid", i), 32'(m_valid), 32'(tbl[i].ev));
            if (tbl[i].cd) check($sformatf("vec%0d_m_data", i), 32'(m_data), 32'(tbl[i].ed));
            check($sformatf("vec%0d_count", i), 32'(fifo_count), 32'(tbl[i].en));
            check($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(tbl[i].eo));
        end
        rx_o_data_valid = 1'b0; m_ready = 1'b0; clr_status = 1'b0;

        // Idle: one pulse 352 ticks after the last push, none after
        push_byte(8'h5A);
        pulses = 0; at = 0;
        for (int k = 1; k <= 420; k++) begin
            step();
            if (idle_irq) begin pulses++; at = k; end
        end
        check("idle_pulses", 32'(pulses), 1);
        check("idle_at", 32'(at), 352);

        // Idle restart: a low tick at count 351 restarts the count
        push_byte(8'hC3);
        pulses = 0; at = 0;
        for (int k = 1; k <= 760; k++) begin
            if (k == 350) i_rx = 1'b0;
            if (k == 351) i_rx = 1'b1;
            step();
            if (idle_irq) begin pulses++; at = k; end
        end
        check("idle_restart_pulses", 32'(pulses), 1);
        check("idle_restart_at", 32'(at), 704);

        // 175 low ticks: no break
        for (int k = 1; k <= 200; k++) begin
            if (k == 1)   i_rx = 1'b0;
            if (k == 176) i_rx = 1'b1;
            step();
        end
        check("no_break_flag", 32'(break_det), 0);
        check("no_break_rx_en", 32'(rx_en), 1);

        // 176 low ticks: break
        for (int k = 1; k <= 178; k++) begin
            if (k == 1) i_rx = 1'b0;
            step();
            if (k == 177) check("brk_177", 32'({break_det, rx_en}), 32'(2'b01));
            if (k == 178) check("brk_178", 32'({break_det, rx_en}), 32'(2'b10));
        end
        for (int k = 1; k <= 19; k++) begin
            if (k == 1) i_rx = 1'b1;
            step();
            if (k == 18) check("recover_18", 32'(rx_en), 0);
            if (k == 19) check("recover_19", 32'(rx_en), 1);
        end
        check("break_sticky", 32'(break_det), 1);
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        check("break_clr", 32'(break_det), 0);

        // Break set in the same clk as clr_status: set wins
        for (int k = 1; k <= 178; k++) begin
            if (k == 1)   i_rx = 1'b0;
            if (k == 178) clr_status = 1'b1;
            step();
        end
        clr_status = 1'b0;
        check("break_set_wins", 32'(break_det), 1);
        for (int k = 1; k <= 19; k++) begin
            if (k == 1) i_rx = 1'b1;
            step();
        end
        check("rerun_rx_en", 32'(rx_en), 1);
        check("fifo_retained", 32'(fifo_count), 2);

        // Async reset mid-RUN, no clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_rx_en", 32'(rx_en), 0);
        check("arst_tick", 32'(baud_tick), 0);
        check("arst_m_valid", 32'(m_valid), 0);
        check("arst_count", 32'(fifo_count), 0);
        check("arst_m_data", 32'(m_data), 0);
        check("arst_break", 32'(break_det), 0);
        step();
        rst_n = 1'b1;
        step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
